// File: rtl/vxc_result_writer_if.sv
// ---------------------------------------------------------------------------
// vxc_result_writer_if
//   Handshake bundle between the complex vector-times-constant add/sub core,
//   the result writer and the result memory.
//
//   Upstream chunk stream : in_valid, in_data, in_ready
//   Memory write port     : mem_we, mem_addr, mem_wdata, mem_ready
//
//   slave  : the writer (consumes the chunk stream, drives the memory port)
//   master : the environment (produces chunks, acknowledges memory writes)
//
//   DW : chunk width (EW*NU of the writer)
//   AW : result memory address width
// ---------------------------------------------------------------------------
interface vxc_result_writer_if #(
    parameter int DW = 512,
    parameter int AW = 16
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/vxc_result_writer.sv
// ---------------------------------------------------------------------------
// vxc_result_writer
//   Downstream stage of the complex vector-times-constant add/sub unit.
//   Accepts chunks of NU complex elements over a valid/ready handshake,
//   buffers them in a FIFO_DEPTH-entry FIFO and writes each chunk to the
//   result memory at base_addr, base_addr+ADDR_STRIDE, ... (mod 2^ADDR_W).
//   finish rises once total/NU chunks have been committed.
//
// Ports
//   clk         : rising-edge clock
//   reset       : asynchronous, active-high reset
//   start       : one-cycle job start, honoured only in IDLE or DONE
//   base_addr   : first write address, latched on start
//   total       : element count of the job, latched on start (floor /NU)
//   bus         : chunk stream (in_*) and memory write port (mem_*)
//   busy        : job in progress (RUN or DRAIN)
//   finish      : job complete, held until next start or reset
//   chunk_count : chunks committed to memory in the current job
//   overflow    : sticky, data offered while no job was active
//
// Parameters
//   EW, NU, ADDR_W, ADDR_STRIDE, FIFO_DEPTH (power of two, >= 2)
// ---------------------------------------------------------------------------
module vxc_result_writer #(
    parameter int EW          = 64,
    parameter int NU          = 8,
    parameter int ADDR_W      = 16,
    parameter int ADDR_STRIDE = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       total,
    vxc_result_writer_if.slave bus,
    output logic              busy,
    output logic              finish,
    output logic [31:0]       chunk_count,
    output logic              overflow
);
    localparam int DW    = EW * NU;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [31:0]       n_chunks;
    logic [31:0]       accepted;
    logic [ADDR_W-1:0] addr_q;

    logic        fifo_full;
    logic        fifo_empty;
    logic        running;
    logic        in_rdy;
    logic        we;
    logic        push;
    logic        pop;
    logic        last_commit;
    logic [31:0] start_chunks;

    always_comb begin
        fifo_full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        fifo_empty   = (fifo_cnt == '0);
        running      = (state == RUN) || (state == DRAIN);
        in_rdy       = (state == RUN) && !fifo_full && (accepted < n_chunks);
        we           = !fifo_empty && running;
        push         = bus.in_valid && in_rdy;
        pop          = we && bus.mem_ready;
        // The commit that completes the job moves straight to DONE so that
        // finish is visible the cycle after the last write.
        last_commit  = pop && ((chunk_count + 32'd1) == n_chunks);
        start_chunks = total / 32'(NU);
    end

    assign bus.in_ready  = in_rdy;
    assign bus.mem_we    = we;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = fifo_mem[rd_ptr];
    assign busy          = running;

    // Chunk storage carries no reset; only the pointers and count do.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            n_chunks    <= '0;
            accepted    <= '0;
            addr_q      <= '0;
            chunk_count <= '0;
            finish      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_chunks    <= start_chunks;
                        accepted    <= '0;
                        chunk_count <= '0;
                        addr_q      <= base_addr;
                        overflow    <= 1'b0;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        fifo_cnt    <= '0;
                        if (start_chunks == '0) begin
                            state  <= DONE;
                            finish <= 1'b1;
                        end else begin
                            state  <= RUN;
                            finish <= 1'b0;
                        end
                    end else if (bus.in_valid) begin
                        overflow <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if (push) begin
                        wr_ptr   <= wr_ptr + PTR_W'(1);
                        accepted <= accepted + 32'd1;
                    end
                    if (pop) begin
                        rd_ptr      <= rd_ptr + PTR_W'(1);
                        addr_q      <= addr_q + ADDR_W'(ADDR_STRIDE);
                        chunk_count <= chunk_count + 32'd1;
                    end
                    case ({push, pop})
                        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                        default: fifo_cnt <= fifo_cnt;
                    endcase
                    if (last_commit) begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end else if ((state == RUN) && (accepted == n_chunks)) begin
                        state <= DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vxc_result_writer.sv
// ---------------------------------------------------------------------------
// tb_vxc_result_writer
//   Directed job sequence with randomized chunk data and memory back-pressure.
//   A queue-based model of the job (pending chunks, accepted/committed counts)
//   predicts the handshake and memory write stream every cycle.
// ---------------------------------------------------------------------------
module tb_vxc_result_writer;
    localparam int EW    = 64;
    localparam int NU    = 8;
    localparam int DW    = EW * NU;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [31:0]   total;
    logic          busy;
    logic          finish;
    logic [31:0]   chunk_count;
    logic          overflow;

    logic          w_start;
    logic [3:0]    w_base;
    logic [31:0]   w_total;
    logic          w_busy;
    logic          w_finish;
    logic [31:0]   w_count;
    logic          w_overflow;

    always #5 clk = ~clk;

    vxc_result_writer_if #(.DW(DW), .AW(AW)) bus ();
    vxc_result_writer_if #(.DW(DW), .AW(4))  bus_w ();

    vxc_result_writer #(
        .EW(EW), .NU(NU), .ADDR_W(AW), .ADDR_STRIDE(1), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .total(total), .bus(bus), .busy(busy), .finish(finish),
        .chunk_count(chunk_count), .overflow(overflow)
    );

    vxc_result_writer #(
        .EW(EW), .NU(NU), .ADDR_W(4), .ADDR_STRIDE(2), .FIFO_DEPTH(DEPTH)
    ) u_wrap (
        .clk(clk), .reset(reset), .start(w_start), .base_addr(w_base),
        .total(w_total), .bus(bus_w), .busy(w_busy), .finish(w_finish),
        .chunk_count(w_count), .overflow(w_overflow)
    );

    int errors = 0;
    int checks = 0;

    // Job model
    logic [DW-1:0] mq[$];
    int unsigned   m_n, m_acc, m_cnt;
    logic [AW-1:0] m_base;
    bit            m_active, m_finish, m_ovf;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkd(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_n = 0; m_acc = 0; m_cnt = 0; m_base = '0;
        m_active = 0; m_finish = 0; m_ovf = 0;
    endtask

    // One clock: check at negedge, then advance the model past the posedge.
    task automatic cycle(output bit pushed);
        bit            exp_rdy, exp_we, s_start, s_valid, pop;
        logic [DW-1:0] s_data;
        logic [AW-1:0] s_base, exp_addr;
        logic [31:0]   s_total;
        @(negedge clk);
        exp_rdy = m_active && (mq.size() < DEPTH) && (m_acc < m_n);
        exp_we  = m_active && (mq.size() != 0);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
        chk("busy", 32'(busy), 32'(m_active));
        chk("finish", 32'(finish), 32'(m_finish));
        chk("chunk_count", chunk_count, m_cnt);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_we) begin
            exp_addr = m_base + AW'(m_cnt);
            chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
            chkd("mem_wdata", bus.mem_wdata, mq[0]);
        end
        s_start = start; s_valid = bus.in_valid; s_data = bus.in_data;
        s_base = base_addr; s_total = total;
        pushed = s_valid && exp_rdy;
        pop    = exp_we && bus.mem_ready;
        @(posedge clk);
        #1;
        if (s_start && !m_active) begin
            m_n = s_total / NU; m_acc = 0; m_cnt = 0; m_base = s_base; m_ovf = 0;
            m_finish = (m_n == 0); m_active = (m_n != 0); mq.delete();
        end else begin
            if (s_valid && !m_active) m_ovf = 1;
            if (pop) begin
                void'(mq.pop_front());
                m_cnt++;
                if (m_cnt == m_n) begin m_active = 0; m_finish = 1; end
            end
            if (pushed) begin mq.push_back(s_data); m_acc++; end
        end
    endtask

    task automatic do_start(logic [AW-1:0] b, logic [31:0] t);
        bit p;
        base_addr = b; total = t; start = 1'b1;
        bus.in_valid = 1'b0; bus.mem_ready = 1'b1;
        cycle(p);
        start = 1'b0;
    endtask

    task automatic steps(int ncyc, int pct, int inj);
        bit p;
        for (int c = 0; c < ncyc; c++) begin
            if (m_finish) break;
            bus.in_valid  = m_active && (m_acc < m_n);
            bus.mem_ready = ($urandom_range(99) < pct);
            if (c == inj) begin start = 1'b1; total = 800; base_addr = 16'hBEEF; end
            cycle(p);
            start = 1'b0;
            if (p) bus.in_data = rand_data();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_to_done(int max_cyc, int pct);
        steps(max_cyc, pct, -1);
        chk("job_finish", 32'(finish), 32'd1);
    endtask

    initial begin
        bit            p;
        int unsigned   wk, wacc;
        logic [DW-1:0] wq[$];

        reset = 1'b1; start = 1'b0; base_addr = '0; total = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.mem_ready = 1'b0;
        w_start = 1'b0; w_base = '0; w_total = '0;
        bus_w.in_valid = 1'b0; bus_w.in_data = '0; bus_w.mem_ready = 1'b0;
        model_reset();
        #12;

        // Reset values
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_count", chunk_count, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Data offered in IDLE: overflow, no write
        bus.in_valid = 1'b1; bus.in_data = rand_data(); bus.mem_ready = 1'b1;
        cycle(p);
        bus.in_valid = 1'b0;
        cycle(p);
        chk("idle_overflow", 32'(overflow), 32'd1);

        // 4 chunks, no back-pressure; start clears overflow
        bus.in_data = rand_data();
        do_start(16'h0010, 32);
        chk("t1_ovf_cleared", 32'(overflow), 32'd0);
        run_to_done(40, 100);
        chk("t1_count", chunk_count, 32'd4);

        // 6 chunks, memory stalled for 10 cycles
        bus.in_data = rand_data();
        do_start(16'h0100, 48);
        steps(10, 0, -1);
        chk("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("t2_addr_hold", 32'(bus.mem_addr), 32'h0100);
        chkd("t2_head_stable", bus.mem_wdata, mq[0]);
        run_to_done(60, 100);
        chk("t2_count", chunk_count, 32'd6);

        // total < NU: no chunks, finish immediately
        do_start(16'h0200, 7);
        chk("t3_finish", 32'(finish), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            bus.mem_ready = 1'b1;
            cycle(p);
        end

        // Start during RUN is ignored; random back-pressure
        bus.in_data = rand_data();
        do_start(16'h0400, 40);
        steps(6, 50, 3);
        run_to_done(200, 50);
        chk("t4_count", chunk_count, 32'd5);
        chk("t4_final_addr", 32'(bus.mem_addr), 32'h0405);

        // Asynchronous reset mid-job
        bus.in_data = rand_data();
        do_start(16'h0800, 40);
        for (int c = 0; c < 40; c++) begin
            if (m_cnt >= 2) break;
            steps(1, 100, -1);
        end
        chk("t5_pre_count", chunk_count, 32'd2);
        #2;
        reset = 1'b1; bus.in_valid = 1'b0;
        #1;
        chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t5_mem_we", 32'(bus.mem_we), 32'd0);
        chk("t5_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_finish", 32'(finish), 32'd0);
        chk("t5_count", chunk_count, 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        model_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        cycle(p);
        bus.in_data = rand_data();
        do_start(16'h0900, 40);
        run_to_done(200, 70);
        chk("t5_new_count", chunk_count, 32'd5);

        // Stride 2, 4-bit address: 0xE then wrap to 0x0
        w_base = 4'hE; w_total = 16; w_start = 1'b1; bus_w.mem_ready = 1'b1;
        @(posedge clk); #1;
        w_start = 1'b0; bus_w.in_valid = 1'b1; bus_w.in_data = rand_data();
        wk = 0; wacc = 0;
        for (int c = 0; c < 20 && wk != 2; c++) begin
            @(negedge clk);
            p = bus_w.in_valid && bus_w.in_ready;
            if (p) begin wq.push_back(bus_w.in_data); wacc++; end
            if (bus_w.mem_we && bus_w.mem_ready) begin
                chk("wrap_addr", 32'(bus_w.mem_addr), 32'(4'(14 + 2 * wk)));
                if (wq.size() != 0) chkd("wrap_data", bus_w.mem_wdata, wq.pop_front());
                else chk("wrap_spurious", 32'(bus_w.mem_we), 32'd0);
                wk++;
            end
            @(posedge clk); #1;
            if (p) bus_w.in_data = rand_data();
            if (wacc >= 2) bus_w.in_valid = 1'b0;
        end
        chk("wrap_commits", wk, 32'd2);
        chk("wrap_finish", 32'(w_finish), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
